// File: rtl/dcache_pkg.sv
// Shared definitions for the data-cache miss/fill controller.
// Holds address field geometry, metadata bit positions, FSM state codes,
// the block size and the victim-selection helper.
package dcache_pkg;

  // Byte address layout: tag [15:10], index [9:4], word [3:1], byte [0].
  localparam int unsigned TagW     = 6;
  localparam int unsigned IndexW   = 6;
  localparam int unsigned WordW    = 3;
  localparam int unsigned TagLsb   = 10;
  localparam int unsigned IndexLsb = 4;

  // Metadata byte layout: [7] valid, [6] LRU, [5:0] tag.
  localparam int unsigned MetaValid = 7;
  localparam int unsigned MetaLru   = 6;

  // Words per block and width of the request/return counters.
  localparam int unsigned Words = 8;
  localparam int unsigned CntW  = 4;

  // FSM state codes.
  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StFill   = 2'd1;
  localparam logic [1:0] StUpdate = 2'd2;

  // Returns 1 when way 2 should be replaced: fill an invalid way first
  // (way 1 preferred), otherwise evict the way marked LRU.
  function automatic logic victim_is_way2(input logic [7:0] meta1, input logic [7:0] meta2);
    if (!meta1[MetaValid])      return 1'b0;
    else if (!meta2[MetaValid]) return 1'b1;
    else if (meta2[MetaLru])    return 1'b1;
    else                        return 1'b0;
  endfunction

endpackage

// File: rtl/onehot_decoder.sv
// Binary to one-hot decoder.
//   sel_i    : binary select, InW bits
//   onehot_o : one-hot output, OutW bits (bit sel_i set)
module onehot_decoder #(
  parameter int unsigned InW  = 3,
  parameter int unsigned OutW = 1 << InW
) (
  input  logic [InW-1:0]  sel_i,
  output logic [OutW-1:0] onehot_o
);

  always_comb begin
    onehot_o        = '0;
    onehot_o[sel_i] = 1'b1;
  end

endmodule

// File: rtl/dcache_fill_ctrl.sv
// Miss-handling controller for the 2-way data cache (64 sets, 8x16-bit words).
// On a miss it picks a victim way, streams 8 read requests to main memory,
// writes each returned word into the victim way and finally rewrites both
// ways' metadata for the set. fsm_busy stalls the pipeline meanwhile.
//   clk, rst                 : clock, synchronous active-high reset
//   miss_detected/address    : miss request from hit-check logic
//   meta_out1/2              : metadata read for the addressed set
//   mem_data/_valid          : in-order memory read returns
//   mem_enable/mem_address   : memory read request
//   block_enable/word_enable : one-hot set / word selects to the cache
//   data_in, data_write1/2   : data array write port
//   meta_in1/2, meta_write1/2: metadata write port
//   fsm_busy, fill_done      : stall indication and completion pulse
module dcache_fill_ctrl
  import dcache_pkg::*;
#(
  parameter int unsigned WORDS       = Words,
  parameter int unsigned MEM_LATENCY = 4  // informational; returns are counted, not timed
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        miss_detected,
  input  logic [15:0] miss_address,
  input  logic [7:0]  meta_out1,
  input  logic [7:0]  meta_out2,
  input  logic [15:0] mem_data,
  input  logic        mem_data_valid,
  output logic        mem_enable,
  output logic [15:0] mem_address,
  output logic [63:0] block_enable,
  output logic [7:0]  word_enable,
  output logic [15:0] data_in,
  output logic        data_write1,
  output logic        data_write2,
  output logic [7:0]  meta_in1,
  output logic [7:0]  meta_in2,
  output logic        meta_write1,
  output logic        meta_write2,
  output logic        fsm_busy,
  output logic        fill_done
);

  if (MEM_LATENCY == 0 || WORDS == 0 || WORDS > (1 << WordW)) begin : g_param_check
    $error("dcache_fill_ctrl: unsupported WORDS/MEM_LATENCY");
  end

  localparam logic [CntW-1:0] WordsCnt = CntW'(WORDS);

  logic [1:0]        state_q, state_d;
  logic [CntW-1:0]   req_cnt_q, req_cnt_d;
  logic [CntW-1:0]   rcv_cnt_q, rcv_cnt_d;
  logic [TagW-1:0]   tag_q, tag_d;
  logic [IndexW-1:0] index_q, index_d;
  logic              victim_q, victim_d;  // 1: way 2 is being filled

  logic [IndexW-1:0] blk_sel;
  logic [7:0]        word_dec;
  logic              wr_en;

  // Word offset and byte bit of the miss address are irrelevant to a block fill;
  // meta_out1[6] is never needed because way 1's LRU bit is always rewritten.
  logic unused_bits;
  assign unused_bits = ^{miss_address[IndexLsb-1:0], meta_out1[MetaLru]};

  always_comb begin
    state_d     = state_q;
    req_cnt_d   = req_cnt_q;
    rcv_cnt_d   = rcv_cnt_q;
    tag_d       = tag_q;
    index_d     = index_q;
    victim_d    = victim_q;
    blk_sel     = index_q;
    wr_en       = 1'b0;
    mem_enable  = 1'b0;
    mem_address = '0;
    data_in     = '0;
    data_write1 = 1'b0;
    data_write2 = 1'b0;
    meta_in1    = '0;
    meta_in2    = '0;
    meta_write1 = 1'b0;
    meta_write2 = 1'b0;
    fsm_busy    = 1'b0;
    fill_done   = 1'b0;

    case (state_q)
      StIdle: begin
        blk_sel = miss_address[IndexLsb +: IndexW];
        if (miss_detected) begin
          tag_d     = miss_address[TagLsb +: TagW];
          index_d   = miss_address[IndexLsb +: IndexW];
          victim_d  = victim_is_way2(meta_out1, meta_out2);
          req_cnt_d = '0;
          rcv_cnt_d = '0;
          state_d   = StFill;
        end
      end

      StFill: begin
        fsm_busy = 1'b1;
        // Request and return paths are independent and may both fire in one cycle.
        if (req_cnt_q < WordsCnt) begin
          mem_enable  = 1'b1;
          mem_address = {tag_q, index_q, req_cnt_q[WordW-1:0], 1'b0};
          req_cnt_d   = req_cnt_q + 4'd1;
        end
        if (mem_data_valid && (rcv_cnt_q < WordsCnt)) begin
          wr_en       = 1'b1;
          data_in     = mem_data;
          data_write1 = ~victim_q;
          data_write2 = victim_q;
          rcv_cnt_d   = rcv_cnt_q + 4'd1;
        end
        // Leave on the cycle carrying the last return so its write lands in FILL.
        if (rcv_cnt_d == WordsCnt) begin
          state_d = StUpdate;
        end
      end

      StUpdate: begin
        fsm_busy    = 1'b1;
        fill_done   = 1'b1;
        meta_write1 = 1'b1;
        meta_write2 = 1'b1;
        // Filled way becomes valid/MRU; the other keeps valid+tag and becomes LRU.
        if (victim_q) begin
          meta_in2 = {1'b1, 1'b0, tag_q};
          meta_in1 = {meta_out1[MetaValid], 1'b1, meta_out1[TagW-1:0]};
        end else begin
          meta_in1 = {1'b1, 1'b0, tag_q};
          meta_in2 = {meta_out2[MetaValid], 1'b1, meta_out2[TagW-1:0]};
        end
        state_d = StIdle;
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      req_cnt_q <= '0;
      rcv_cnt_q <= '0;
      tag_q     <= '0;
      index_q   <= '0;
      victim_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      req_cnt_q <= req_cnt_d;
      rcv_cnt_q <= rcv_cnt_d;
      tag_q     <= tag_d;
      index_q   <= index_d;
      victim_q  <= victim_d;
    end
  end

  onehot_decoder #(
    .InW  (IndexW),
    .OutW (64)
  ) u_block_dec (
    .sel_i    (blk_sel),
    .onehot_o (block_enable)
  );

  onehot_decoder #(
    .InW  (WordW),
    .OutW (8)
  ) u_word_dec (
    .sel_i    (rcv_cnt_q[WordW-1:0]),
    .onehot_o (word_dec)
  );

  assign word_enable = wr_en ? word_dec : 8'h00;

endmodule

// File: tb/tb_dcache_fill_ctrl.sv
// Scoreboard bench for dcache_fill_ctrl: the stimulus side pushes the expected
// memory requests, data-array writes and metadata update of each miss; a
// monitor pops and compares whenever the DUT strobes. A small memory model
// returns data in order after a 4-cycle latency, optionally with gaps.
module tb_dcache_fill_ctrl;

  localparam int unsigned Lat = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        miss_detected;
  logic [15:0] miss_address;
  logic [7:0]  meta_out1, meta_out2;
  logic [15:0] mem_data;
  logic        mem_data_valid = 1'b0;
  logic        mem_enable;
  logic [15:0] mem_address;
  logic [63:0] block_enable;
  logic [7:0]  word_enable;
  logic [15:0] data_in;
  logic        data_write1, data_write2;
  logic [7:0]  meta_in1, meta_in2;
  logic        meta_write1, meta_write2;
  logic        fsm_busy, fill_done;

  always #5 clk = ~clk;

  dcache_fill_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .miss_detected  (miss_detected),
    .miss_address   (miss_address),
    .meta_out1      (meta_out1),
    .meta_out2      (meta_out2),
    .mem_data       (mem_data),
    .mem_data_valid (mem_data_valid),
    .mem_enable     (mem_enable),
    .mem_address    (mem_address),
    .block_enable   (block_enable),
    .word_enable    (word_enable),
    .data_in        (data_in),
    .data_write1    (data_write1),
    .data_write2    (data_write2),
    .meta_in1       (meta_in1),
    .meta_in2       (meta_in2),
    .meta_write1    (meta_write1),
    .meta_write2    (meta_write2),
    .fsm_busy       (fsm_busy),
    .fill_done      (fill_done)
  );

  typedef struct packed {
    logic        dw1;
    logic        dw2;
    logic [7:0]  we;
    logic [15:0] data;
    logic [63:0] blk;
  } wr_t;

  typedef struct packed {
    logic [7:0]  mi1;
    logic [7:0]  mi2;
    logic [63:0] blk;
  } meta_t;

  typedef struct packed {
    logic [15:0] addr;
    int unsigned ready;
  } pend_t;

  wr_t         wr_q[$];
  meta_t       meta_q[$];
  logic [15:0] addr_q[$];
  pend_t       pend_q[$];
  int unsigned len_q[$];

  int          checks = 0;
  int          errors = 0;
  int unsigned cyc = 0;
  int          done_cnt = 0;
  int          wr_seen = 0;
  int          busy_run = 0;
  logic        prev_done = 1'b0;
  int          gap_mode = 0;  // 0: no gaps, 1: random gaps, 2: alternate 1,0,1
  logic        alt = 1'b0;
  logic        spur = 1'b0;

  function automatic logic [15:0] mem_fn(input logic [15:0] a);
    return (a ^ 16'hA5A5) + {a[7:0], a[15:8]};
  endfunction

  function automatic logic [63:0] onehot64(input logic [5:0] i);
    return 64'd1 << i;
  endfunction

  // Replacement choice: first invalid way (way 1 first), else the LRU way.
  function automatic logic pick_way2(input logic [7:0] m1, input logic [7:0] m2);
    if (m1[7] == 1'b0) return 1'b0;
    if (m2[7] == 1'b0) return 1'b1;
    return m2[6];
  endfunction

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic push_exp(input logic [15:0] addr, input logic [7:0] m1, input logic [7:0] m2,
                          input bit chk_len);
    logic [5:0]  tag;
    logic [5:0]  idx;
    logic        v2;
    logic [15:0] a;
    wr_t         w;
    meta_t       m;
    tag = addr[15:10];
    idx = addr[9:4];
    v2  = pick_way2(m1, m2);
    for (int i = 0; i < 8; i++) begin
      a      = {tag, idx, 3'(i), 1'b0};
      addr_q.push_back(a);
      w.dw1  = ~v2;
      w.dw2  = v2;
      w.we   = 8'd1 << i;
      w.data = mem_fn(a);
      w.blk  = onehot64(idx);
      wr_q.push_back(w);
    end
    if (v2) begin
      m.mi2 = {2'b10, tag};
      m.mi1 = {m1[7], 1'b1, m1[5:0]};
    end else begin
      m.mi1 = {2'b10, tag};
      m.mi2 = {m2[7], 1'b1, m2[5:0]};
    end
    m.blk = onehot64(idx);
    meta_q.push_back(m);
    if (chk_len) len_q.push_back(13);  // 12 FILL cycles + 1 UPDATE with gap-free memory
  endtask

  task automatic wait_done(input int prev);
    int n;
    n = 0;
    while (done_cnt == prev && n < 300) begin
      @(posedge clk);
      #2;
      n++;
    end
    if (done_cnt == prev) begin
      checks++;
      errors++;
      $display("FAIL fill_timeout: got no fill_done, expected one within 300 cycles");
    end
  endtask

  task automatic run_fill(input logic [15:0] addr, input logic [7:0] m1, input logic [7:0] m2,
                          input int gm, input bit chk_len);
    int prev;
    @(posedge clk);
    #2;
    gap_mode      = gm;
    meta_out1     = m1;
    meta_out2     = m2;
    miss_detected = 1'b1;
    miss_address  = addr;
    push_exp(addr, m1, m2, chk_len);
    prev = done_cnt;
    @(posedge clk);
    #2;
    miss_detected = 1'b0;
    miss_address  = 16'($urandom);  // must not disturb the latched fill
    wait_done(prev);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Memory model: in-order returns no earlier than Lat cycles after the request.
  logic  go;
  pend_t pq;
  always @(posedge clk) begin
    #1;
    mem_data_valid = 1'b0;
    mem_data       = 16'($urandom);
    if (spur) begin
      mem_data_valid = 1'b1;
    end else if (pend_q.size() > 0 && pend_q[0].ready <= cyc) begin
      alt = ~alt;
      if (gap_mode == 0)      go = 1'b1;
      else if (gap_mode == 1) go = 1'($urandom_range(0, 1));
      else                    go = alt;
      if (go) begin
        pq             = pend_q.pop_front();
        mem_data_valid = 1'b1;
        mem_data       = mem_fn(pq.addr);
      end
    end
  end

  // Monitor / scoreboard.
  logic [15:0] ea;
  wr_t         ew;
  meta_t       em;
  pend_t       np;
  always @(negedge clk) begin
    if (mem_enable) begin
      if (addr_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_request: got mem_address %h, expected no request", mem_address);
      end else begin
        ea = addr_q.pop_front();
        check("mem_address", 128'(mem_address), 128'(ea));
      end
      np.addr  = mem_address;
      np.ready = cyc + Lat;
      pend_q.push_back(np);
    end
    if (data_write1 || data_write2) begin
      wr_seen++;
      if (wr_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got data_write %b%b, expected none",
                 data_write1, data_write2);
      end else begin
        ew = wr_q.pop_front();
        check("data_write", 128'({data_write1, data_write2, word_enable, data_in, block_enable}),
              128'(ew));
      end
    end
    if (meta_write1 || meta_write2 || fill_done) begin
      done_cnt++;
      wr_seen = 0;
      check("writes_before_update", 128'(wr_q.size()), 128'(0));
      if (meta_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_update: got meta_write %b%b, expected none",
                 meta_write1, meta_write2);
      end else begin
        em = meta_q.pop_front();
        check("meta_update",
              128'({meta_write1, meta_write2, fill_done, fsm_busy, meta_in1, meta_in2,
                    block_enable}),
              128'({4'b1111, em}));
      end
    end
    if (prev_done) check("busy_after_done", 128'(fsm_busy), 128'(0));
    prev_done = fill_done;
    if (fsm_busy) begin
      busy_run++;
    end else if (busy_run > 0) begin
      if (len_q.size() > 0) check("busy_cycles", 128'(busy_run), 128'(len_q.pop_front()));
      busy_run = 0;
    end
    // Memory and controller both reset on the next edge: drop everything in flight.
    if (rst) begin
      pend_q.delete();
      wr_q.delete();
      meta_q.delete();
      addr_q.delete();
      len_q.delete();
      busy_run = 0;
      wr_seen  = 0;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          n;
    int          prev;
    int          gm;
    logic [15:0] a;
    logic [15:0] b;
    rst           = 1'b1;
    miss_detected = 1'b0;
    miss_address  = 16'h1234;
    meta_out1     = 8'h00;
    meta_out2     = 8'h00;
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b0;
    @(negedge clk);
    check("reset_strobes", 128'({fsm_busy, fill_done, mem_enable, data_write1, data_write2,
                                 meta_write1, meta_write2, word_enable}), 128'(0));
    check("reset_values", 128'({mem_address, data_in, meta_in1, meta_in2}), 128'(0));
    check("reset_block_enable", 128'(block_enable), 128'(onehot64(6'h23)));

    // Cold miss: both ways invalid -> way 1, meta_in1 = 0x84.
    run_fill(16'h1234, 8'h00, 8'h00, 0, 1'b1);
    // Set full, way 2 LRU, tag 0x07 -> way 2, meta_in2 = 0x87, meta_in1 = 0xC5.
    run_fill(16'h1D56, 8'h85, 8'hC3, 0, 1'b1);
    // Alternating returns.
    run_fill(16'($urandom), 8'($urandom), 8'($urandom), 2, 1'b0);
    // Randomised fills.
    for (int i = 0; i < 8; i++) begin
      gm = int'($urandom_range(0, 1));
      run_fill(16'($urandom), 8'($urandom), 8'($urandom), gm, gm == 0);
    end

    // Reset after three returns abandons the fill.
    @(posedge clk);
    #2;
    gap_mode      = 1;
    meta_out1     = 8'($urandom);
    meta_out2     = 8'($urandom);
    a             = 16'($urandom);
    miss_address  = a;
    miss_detected = 1'b1;
    push_exp(a, meta_out1, meta_out2, 1'b0);
    @(posedge clk);
    #2;
    miss_detected = 1'b0;
    n = 0;
    while (wr_seen < 3 && n < 200) begin
      @(posedge clk);
      #2;
      n++;
    end
    check("three_returns_seen", 128'(wr_seen >= 3), 128'(1));
    rst = 1'b1;
    @(posedge clk);
    #2;
    rst = 1'b0;
    @(negedge clk);
    check("midfill_reset_strobes",
          128'({fsm_busy, fill_done, mem_enable, data_write1, data_write2, meta_write1,
                meta_write2}), 128'(0));
    // A fresh miss must restart from word 0.
    run_fill(16'($urandom), 8'($urandom), 8'($urandom), 0, 1'b1);

    // miss_detected held through the fill: second address only taken after fill_done.
    a = 16'($urandom);
    b = 16'($urandom);
    @(posedge clk);
    #2;
    gap_mode      = 1;
    meta_out1     = 8'hC9;
    meta_out2     = 8'h8E;
    miss_address  = a;
    miss_detected = 1'b1;
    push_exp(a, meta_out1, meta_out2, 1'b0);
    prev = done_cnt;
    @(posedge clk);
    #2;
    miss_address = b;
    wait_done(prev);
    push_exp(b, meta_out1, meta_out2, 1'b0);
    prev = done_cnt;
    @(posedge clk);
    #2;
    miss_detected = 1'b0;
    wait_done(prev);

    // Stray mem_data_valid while idle must not write anything.
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #2;
      spur = 1'b1;
      @(posedge clk);
      @(negedge clk);
      spur = 1'b0;
      check("idle_valid_ignored",
            128'({data_write1, data_write2, meta_write1, meta_write2, fsm_busy, word_enable}),
            128'(0));
    end

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("scoreboard_drained", 128'(wr_q.size() + meta_q.size() + addr_q.size()), 128'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dcache_fill_ctrl.md
Name: dcache_fill_ctrl

Overview:
- Miss-handling controller placed directly upstream of the 2-way data cache storage (64 sets, 8×16-bit words per block, 8-bit metadata per way).
- On a miss it chooses a victim way and fetches the 8-word block from multi-cycle main memory.
- It writes each returned word into the data array, then rewrites both ways' metadata for that set.
- It holds fsm_busy so the pipeline stalls until the fill completes.

Parameters:
- WORDS, 8, words per block; sets the request and return count limits.
- MEM_LATENCY, 4, nominal memory read latency in cycles. Informational only: the controller counts data_valid returns and does not time the latency.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- miss_detected  in  1  miss request from the hit-check logic, valid this cycle
- miss_address  in  16  byte address of the miss: tag [15:10], index [9:4], word [3:1]
- meta_out1  in  8  metadata read for way 1: [7] valid, [6] LRU, [5:0] tag
- meta_out2  in  8  metadata read for way 2, same format
- mem_data  in  16  memory read data
- mem_data_valid  in  1  mem_data valid this cycle; returns arrive in request order
- mem_enable  out  1  memory read request strobe
- mem_address  out  16  memory read address
- block_enable  out  64  one-hot set select to the cache
- word_enable  out  8  one-hot word select to the data array
- data_in  out  16  write data to the data array
- data_write1  out  1  data array write strobe, way 1
- data_write2  out  1  data array write strobe, way 2
- meta_in1  out  8  metadata write value, way 1
- meta_in2  out  8  metadata write value, way 2
- meta_write1  out  1  metadata write strobe, way 1
- meta_write2  out  1  metadata write strobe, way 2
- fsm_busy  out  1  fill in progress; pipeline must stall
- fill_done  out  1  one-cycle pulse when the fill completes

Behaviour:
- States:
  - IDLE, FILL, UPDATE.
  - Reset forces IDLE and clears req_cnt, rcv_cnt and the latched registers.
  - Reset mid-fill abandons the fill with no metadata write. Memory shares rst, so no stale returns arrive after reset.
- Output reset values:
  - All strobes, fsm_busy and fill_done are 0.
  - mem_address, data_in, meta_in1 and meta_in2 are 0.
  - block_enable is decoded from miss_address[9:4] (combinational in IDLE).
- IDLE:
  - block_enable = onehot(miss_address[9:4]); no writes.
  - When miss_detected=1, latch tag, index and victim, then go to FILL next cycle.
  - Victim rule, in priority order:
    - way 1 if meta_out1[7]=0;
    - else way 2 if meta_out2[7]=0;
    - else way 2 if meta_out2[6]=1;
    - else way 1.
  - mem_data_valid is ignored in IDLE.
- FILL:
  - fsm_busy=1; block_enable = onehot(latched index).
  - Requests: mem_enable=1 while req_cnt<WORDS, with mem_address={tag,index,req_cnt[2:0],1'b0}; req_cnt increments each such cycle. This gives 8 back-to-back requests starting in the first FILL cycle.
  - Returns: on mem_data_valid=1, data_in=mem_data and word_enable=onehot(rcv_cnt[2:0]). data_write of the victim way = 1 and the other = 0. rcv_cnt then increments.
  - A request and a return in the same cycle are both serviced.
  - Once rcv_cnt=WORDS, go to UPDATE. The last return's write happens in the final FILL cycle.
- UPDATE (one cycle):
  - fsm_busy=1, fill_done=1, meta_write1=meta_write2=1.
  - Victim way: {1'b1, 1'b0, tag}. Other way: {its valid, 1'b1, its tag}, taken from meta_outN as read now.
  - Next state IDLE; fsm_busy drops in the following cycle.
- A miss_detected asserted while not in IDLE is ignored. Upstream keeps it asserted because of the stall.
- Timing: with 4-cycle memory latency, a fill takes 1 (accept) + 12 (FILL) + 1 (UPDATE) cycles.
- Counters: 4-bit req_cnt and rcv_cnt, saturating at WORDS with no wrap; both clear on entry to FILL.

Decomposition:
- Shared package dcache_pkg holds:
  - address field widths and offsets (TAG 6, INDEX 6, WORD 3);
  - metadata bit positions (VALID 7, LRU 6);
  - the state enum {IDLE, FILL, UPDATE};
  - the WORDS constant.
- The 6-to-64 and 3-to-8 one-hot decoders are a single natural sub-module, onehot_decoder, parameterised by width and used for both block_enable and word_enable.

Test Plan:
- Cold miss, both ways invalid: miss_address=0x1234 -> victim way 1; mem_address runs 0x1230..0x123E, step 2; 8 data_write1 pulses with word_enable 0x01..0x80; UPDATE meta_in1=0x84, meta_write1=meta_write2=1; fill_done pulses once.
- Set full, way 2 LRU: meta_out1=0x85, meta_out2=0xC3, miss tag 0x07 -> victim way 2; data_write2 only; meta_in2=0x87, meta_in1=0xC5.
- Memory returns with gaps (data_valid 1,0,1,...): exactly 8 writes, word order 0..7 preserved; fsm_busy stays high until the cycle after UPDATE.
- Reset asserted after 3 returns -> next cycle IDLE, all strobes 0; a new miss then restarts from req_cnt=0.
- miss_detected held high during FILL -> no re-latch; after fill_done the next IDLE cycle accepts the request again.
- mem_data_valid pulses in IDLE -> no data_write or meta_write asserted.
